imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbitrates the core's single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU). It sits between both units and the memory model, which holds the image loaded at `PcRst`. It serialises one transaction at a time through a four-state FSM. Policy is fixed priority to the LSU, with a starvation guard for the IFU. IFU fetches that are not word-aligned are rejected without touching memory.

## Interface
- `ADDR_W`, 32: address width (matches `RegWidth`).
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 4: number of consecutive LSU grants allowed while the IFU is waiting; range 1..15.
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `if_req_valid` in 1, `if_req_ready` out 1, `if_addr` in ADDR_W: IFU fetch request.
- `if_resp_valid` out 1, `if_resp_ready` in 1, `if_rdata` out DATA_W, `if_resp_err` out 1: IFU response.
- `ls_req_valid` in 1, `ls_req_ready` out 1, `ls_addr` in ADDR_W, `ls_wen` in 1, `ls_wdata` in DATA_W, `ls_wmask` in DATA_W/8: LSU request.
- `ls_resp_valid` out 1, `ls_resp_ready` in 1, `ls_rdata` out DATA_W: LSU response. Writes also return a response; its data is don't-care.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_addr` out ADDR_W, `mem_wen` out 1, `mem_wdata` out DATA_W, `mem_wmask` out DATA_W/8: memory request.
- `mem_resp_valid` in 1, `mem_rdata` in DATA_W: memory response, one per accepted request. Responses are in order.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - The grant is combinational. The LSU wins if `ls_req_valid` is high, unless the starvation count equals STARVE_LIMIT and `if_req_valid` is high, in which case the IFU wins.
  - Only the granted requester sees `*_req_ready`=1.
  - On handshake, latch owner, addr, wen, wdata and wmask, then go to REQ.
  - An IFU request with `if_addr[1:0]`≠0 goes directly to RESP with err=1 and rdata=0. It never reaches memory.
- REQ: `mem_req_valid`=1 with the latched fields, held stable. On `mem_req_ready`, go to WAIT.
- WAIT: on `mem_resp_valid`, latch `mem_rdata` and go to RESP. `mem_resp_valid` is ignored in any other state.
- RESP:
  - The owner's `*_resp_valid`=1 with the latched rdata and err, held stable.
  - On the owner's `*_resp_ready`, go to IDLE. A new request cannot be accepted in this same cycle.
- IFU requests always drive `mem_wen`=0 and `mem_wmask`=0.
- Starvation counter (4 bits):
  - Increments on an LSU grant while `if_req_valid` is high.
  - Clears on any IFU grant, and on an LSU grant while `if_req_valid` is low.
  - Saturates at STARVE_LIMIT.
- Requests on the non-granted port are held off by ready=0. The requester must keep valid and payload stable until accepted.

## Timing
- Reset values: all `*_ready`, `*_valid`, `mem_wen` and `if_resp_err` are 0; all data and address outputs are 0; state is IDLE; counter is 0.
- Reset mid-transaction drops the transaction and issues no response. The memory model must be reset in the same cycle.
- Minimum latency is 3 cycles from the request handshake (cycle 0) to `resp_valid` (cycle 3), with `mem_req_ready`=1 in cycle 1 and `mem_resp_valid` in cycle 2.
- Each cycle of backpressure on `mem_req_ready`, latency on `mem_resp_valid`, or delay on `resp_ready` adds exactly 1 cycle.
- Misaligned IFU request: `if_resp_valid` is asserted in cycle 1.
- Simultaneous valid on both ports: exactly one ready. The loser's request is untouched.
- Throughput is at most one transaction per 4 cycles. No outstanding-request pipelining.

## Structure
- Shared `defines.v` holds:
  - the FSM encoding `ARB_IDLE/REQ/WAIT/RESP` (2 bits);
  - the owner encoding `OWN_IF/OWN_LS`;
  - reuse of `RegWidth`/`Vec` for widths.
- One sub-module, `arb_grant`: the combinational priority select plus the starvation counter register. Its outputs are `grant_if` and `grant_ls`.
- The top level holds the FSM and the transaction latches.

## Test plan
- Reset then idle: all outputs 0. `if_req_valid`=1, addr 0x80000004, memory ready and 1-cycle response 0x00100073 → `if_resp_valid` in cycle 3 with rdata 0x00100073 and err=0.
- Both ports valid continuously, STARVE_LIMIT=4, LSU reads → grant order LS, LS, LS, LS, IF, LS…; counter returns to 0 after the IF grant.
- LSU write, addr 0x80000100, wdata 0xDEADBEEF, wmask 0xF, then LSU read of the same addr → `mem_wen`=1 in REQ; the read returns 0xDEADBEEF.
- `mem_req_ready` low for 3 cycles and `resp_ready` low for 2 cycles → request fields stable throughout; response after 3+3+2 = 8 cycles.
- IFU addr 0x80000002 → no `mem_req_valid`; `if_resp_valid` in cycle 1 with err=1 and rdata 0.
- `rst_n` low in WAIT → next cycle state is IDLE with all outputs 0. A stale `mem_resp_valid` afterwards produces no response.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared encodings and widths for the IFU/LSU memory-port arbiter.
package imem_arbiter_pkg;
    localparam int RegWidth = 32;
    localparam int CNT_W    = 4;

    typedef logic [RegWidth-1:0] vec_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;
endpackage

// File: rtl/imem_arbiter_grant.sv
// arb_grant: LSU-priority select with an IFU starvation guard.
module imem_arbiter_grant
    import imem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic if_req_valid,
    input  logic ls_req_valid,
    output logic grant_if,
    output logic grant_ls
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_starved;

    assign w_starved = (r_cnt == LIMIT) && if_req_valid;
    assign grant_ls  = en && ls_req_valid && !w_starved;
    assign grant_if  = en && if_req_valid && !grant_ls;

    // A grant is always a handshake, since only the valid requester is granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (grant_if) begin
            r_cnt <= '0;
        end else if (grant_ls) begin
            if (!if_req_valid)
                r_cnt <= '0;
            else if (r_cnt != LIMIT)
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/imem_arbiter.sv
// Serialises IFU and LSU transactions onto the single memory port.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = RegWidth,
    parameter int DATA_W       = RegWidth,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_resp_valid,
    input  logic                if_resp_ready,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_resp_err,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_resp_valid,
    input  logic                ls_resp_ready,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    arb_state_e          r_state, w_state_nxt;
    owner_e              r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wmask;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                w_idle, w_grant_if, w_grant_ls, w_misalign, w_resp_hs;

    // Grants are masked in reset so no ready leaks out while rst_n is low.
    assign w_idle     = (r_state == ARB_IDLE) && rst_n;
    assign w_misalign = (if_addr[1:0] != 2'b00);
    assign w_resp_hs  = (r_state == ARB_RESP) &&
                        ((r_owner == OWN_IF) ? if_resp_ready : ls_resp_ready);

    imem_arbiter_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (w_idle),
        .if_req_valid (if_req_valid),
        .ls_req_valid (ls_req_valid),
        .grant_if     (w_grant_if),
        .grant_ls     (w_grant_ls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ARB_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_if)      w_state_nxt = w_misalign ? ARB_RESP : ARB_REQ;
                else if (w_grant_ls) w_state_nxt = ARB_REQ;
            end
            ARB_REQ:  if (mem_req_ready)  w_state_nxt = ARB_WAIT;
            ARB_WAIT: if (mem_resp_valid) w_state_nxt = ARB_RESP;
            ARB_RESP: if (w_resp_hs)      w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    // A misaligned fetch is answered from here with rdata 0 and err 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_grant_if) begin
            r_owner <= OWN_IF;
            r_addr  <= if_addr;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
            r_rdata <= '0;
            r_err   <= w_misalign;
        end else if (w_grant_ls) begin
            r_owner <= OWN_LS;
            r_addr  <= ls_addr;
            r_wen   <= ls_wen;
            r_wdata <= ls_wdata;
            r_wmask <= ls_wmask;
            r_err   <= 1'b0;
        end else if (r_state == ARB_WAIT && mem_resp_valid) begin
            r_rdata <= mem_rdata;
        end
    end

    assign if_req_ready  = w_grant_if;
    assign ls_req_ready  = w_grant_ls;
    assign mem_req_valid = (r_state == ARB_REQ);
    assign mem_addr      = r_addr;
    assign mem_wen       = r_wen;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;
    assign if_resp_valid = (r_state == ARB_RESP) && (r_owner == OWN_IF);
    assign ls_resp_valid = (r_state == ARB_RESP) && (r_owner == OWN_LS);
    assign if_rdata      = r_rdata;
    assign ls_rdata      = r_rdata;
    assign if_resp_err   = r_err;
endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a small in-order memory model.
module tb_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req_valid, ls_req_ready, ls_wen, ls_resp_valid, ls_resp_ready;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [3:0]  ls_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
        .if_rdata(if_rdata), .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_wen(ls_wen), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready), .ls_rdata(ls_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory model: word array indexed by addr[9:2], image reloaded on reset.
    logic [31:0] mem [0:255];
    logic        m_vld, stale_inj;
    logic [31:0] m_rdata, pend;
    int          lat_extra = 0;
    int          cd;
    assign mem_resp_valid = m_vld | stale_inj;
    assign mem_rdata      = m_rdata;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        m_vld <= 1'b0;
        if (!rst_n) begin
            cd <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[1]   <= 32'h0010_0073;
            mem[128] <= 32'h1122_3344;
        end else begin
            if (cd == 1) begin m_vld <= 1'b1; m_rdata <= pend; end
            if (cd != 0) cd <= cd - 1;
            if (mem_req_valid && mem_req_ready) begin
                if (lat_extra == 0) begin
                    m_vld <= 1'b1; m_rdata <= mem[mem_addr[9:2]];
                end else begin
                    cd <= lat_extra; pend <= mem[mem_addr[9:2]];
                end
                if (mem_wen) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_wdata, mem_wmask);
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk_data;
        int          due;
    } exp_t;
    exp_t q_if[$];
    exp_t q_ls[$];

    // Monitor: compares every response handshake against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && if_resp_valid && if_resp_ready) begin
                if (q_if.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_resp_unexpected got=%h want=none (cycle %0d)", if_rdata, cyc);
                end else begin
                    e = q_if.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_err", {31'h0, if_resp_err}, {31'h0, e.err});
                    chk("if_latency", cyc, e.due);
                end
            end
            if (rst_n && ls_resp_valid && ls_resp_ready) begin
                if (q_ls.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ls_resp_unexpected got=%h want=none (cycle %0d)", ls_rdata, cyc);
                end else begin
                    e = q_ls.pop_front();
                    if (e.chk_data) chk("ls_rdata", ls_rdata, e.data);
                    chk("ls_latency", cyc, e.due);
                end
            end
        end
    end

    task automatic wait_hs(input bit is_ls, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (is_ls ? ls_req_ready : if_req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL req_handshake_timeout got=none want=ready (cycle %0d)", cyc);
        end
    endtask

    // One transaction with `stall` cycles of mem_req_ready low and `rd` cycles of resp_ready low.
    task automatic do_req(input bit is_ls, input logic [31:0] addr, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [31:0] exp_data, input bit chk_data,
                          input int stall, input int rd);
        bit   ok, mis;
        exp_t e;
        mis = !is_ls && (addr[1:0] != 2'b00);
        @(posedge clk); #1;
        mem_req_ready = (stall == 0);
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_addr = addr; ls_wen = wen; ls_wdata = wdata; ls_wmask = wmask;
            ls_resp_ready = (rd == 0);
        end else begin
            if_req_valid = 1'b1; if_addr = addr; if_resp_ready = (rd == 0);
        end
        wait_hs(is_ls, ok);
        if (ok) begin
            e.data = mis ? 32'h0 : exp_data;
            e.err = mis;
            e.chk_data = chk_data;
            e.due = cyc + (mis ? 1 : 3 + stall + rd);
            if (is_ls) q_ls.push_back(e); else q_if.push_back(e);
        end
        for (int i = 0; i <= (mis ? 0 : stall); i++) begin
            @(posedge clk); #1;
            if_req_valid = 1'b0; ls_req_valid = 1'b0;
            mem_req_ready = (i >= stall);
            @(negedge clk);
            if (mis) begin
                chk("misalign_no_mem_req", {31'h0, mem_req_valid}, 32'h0);
            end else begin
                chk("req_valid", {31'h0, mem_req_valid}, 32'h1);
                chk("req_addr", mem_addr, addr);
                chk("req_wen", {31'h0, mem_wen}, {31'h0, is_ls & wen});
                chk("req_wmask", {28'h0, mem_wmask}, is_ls ? {28'h0, wmask} : 32'h0);
                if (is_ls && wen) chk("req_wdata", mem_wdata, wdata);
            end
        end
        if (rd > 0) begin
            repeat (2 + rd) @(posedge clk);
            #1;
            if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (q_if.size() != 0 || q_ls.size() != 0); n++) @(negedge clk);
        chk("drain_if", q_if.size(), 0);
        chk("drain_ls", q_ls.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          ngrant;
        logic [9:0]  order;
        exp_t        e;
        rst_n = 1'b0; stale_inj = 1'b0;
        if_req_valid = 0; if_addr = 0; if_resp_ready = 1;
        ls_req_valid = 0; ls_addr = 0; ls_wen = 0; ls_wdata = 0; ls_wmask = 0; ls_resp_ready = 1;
        mem_req_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid,
                              ls_resp_valid, mem_wen, if_resp_err}, 32'h0);
        chk("reset_data", mem_addr | mem_wdata | if_rdata | ls_rdata | {28'h0, mem_wmask}, 32'h0);
        @(posedge clk); #1; rst_n = 1'b1;

        do_req(0, 32'h8000_0004, 0, 0, 0, 32'h0010_0073, 1, 0, 0);
        drain();
        do_req(1, 32'h8000_0100, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 0);
        drain();
        do_req(1, 32'h8000_0100, 0, 0, 0, 32'hDEAD_BEEF, 1, 0, 0);
        drain();
        do_req(0, 32'h8000_0004, 0, 0, 0, 32'h0010_0073, 1, 3, 2);
        drain();
        do_req(0, 32'h8000_0002, 0, 0, 0, 32'h0, 1, 0, 0);
        drain();

        // Both ports valid continuously: LSU x4, then the starved IFU wins.
        order = 10'b10_0001_0000;
        ngrant = 0;
        @(posedge clk); #1;
        if_req_valid = 1; if_addr = 32'h8000_0004;
        ls_req_valid = 1; ls_addr = 32'h8000_0200; ls_wen = 0;
        for (int n = 0; n < 100 && ngrant < 10; n++) begin
            @(negedge clk);
            if (if_req_ready || ls_req_ready) begin
                chk("one_ready", $countones({if_req_ready, ls_req_ready}), 1);
                chk($sformatf("grant_%0d_is_if", ngrant), {31'h0, if_req_ready}, {31'h0, order[ngrant]});
                e.err = 0; e.chk_data = 1; e.due = cyc + 3;
                if (if_req_ready) begin e.data = 32'h0010_0073; q_if.push_back(e); end
                else              begin e.data = 32'h1122_3344; q_ls.push_back(e); end
                ngrant++;
            end
        end
        chk("starve_grant_count", ngrant, 10);
        @(posedge clk); #1;
        if_req_valid = 0; ls_req_valid = 0;
        drain();

        // Reset while waiting on memory: no response, stale mem_resp_valid ignored.
        lat_extra = 5;
        @(posedge clk); #1;
        ls_req_valid = 1; ls_addr = 32'h8000_0200; ls_wen = 0;
        wait_hs(1, ok);
        @(posedge clk); #1; ls_req_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_no_req", {31'h0, mem_req_valid | ls_resp_valid}, 32'h0);
        @(posedge clk); #1; rst_n = 0;
        @(posedge clk); #1; rst_n = 1; lat_extra = 0;
        @(negedge clk);
        chk("post_reset_outputs", {if_req_ready, ls_req_ready, mem_req_valid, if_resp_valid,
                                   ls_resp_valid, mem_wen, if_resp_err}, 32'h0);
        chk("post_reset_data", mem_addr | mem_wdata | if_rdata | ls_rdata | {28'h0, mem_wmask}, 32'h0);
        @(posedge clk); #1; stale_inj = 1;
        @(posedge clk); #1; stale_inj = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stale_no_resp", {31'h0, if_resp_valid | ls_resp_valid | mem_req_valid}, 32'h0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
